// File: rtl/mac_tx_fcs_insert_pkg.sv
// rtl/mac_tx_fcs_insert_pkg.sv - shared MAC constants, TX FCS state type and bit-reverse helper
package mac_tx_fcs_insert_pkg;

  localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

  localparam int ETH_MIN_FRAME_LEN = 60;
  localparam int ETH_FCS_LEN       = 4;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAD,
    FCS
  } tx_fcs_state_t;

  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_tx_fcs_insert_lfsr.sv
// rtl/mac_tx_fcs_insert_lfsr.sv - mac_lfsr: 32-bit Galois LFSR, DATA_WIDTH bits per step
// REVERSE=1 shifts LSB-first with the reflected polynomial (Ethernet bit order).
module mac_lfsr
  import mac_tx_fcs_insert_pkg::*;
#(
  parameter logic [31:0] LFSR_POLY   = CRC32_POLY,
  parameter logic [31:0] LFSR_INIT   = CRC32_INIT,
  parameter logic [31:0] LFSR_XOROUT = CRC32_XOROUT,
  parameter bit          REVERSE     = 1'b1,
  parameter int          DATA_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  output logic [31:0]           o_lfsr_state
);

  localparam logic [31:0] POLY_EFF = REVERSE ? bit_reverse32(LFSR_POLY) : LFSR_POLY;

  logic [31:0] r_state;
  logic [31:0] w_next;
  logic        w_fb;

  always_comb begin
    w_next = r_state;
    w_fb   = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (REVERSE) begin
        w_fb   = w_next[0] ^ i_data[i];
        w_next = {1'b0, w_next[31:1]} ^ (w_fb ? POLY_EFF : 32'h0);
      end else begin
        w_fb   = w_next[31] ^ i_data[DATA_WIDTH-1-i];
        w_next = {w_next[30:0], 1'b0} ^ (w_fb ? POLY_EFF : 32'h0);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= LFSR_INIT;
    end else if (i_data_valid) begin
      r_state <= w_next;
    end
  end

  assign o_lfsr_state = r_state ^ LFSR_XOROUT;

endmodule

// File: rtl/mac_tx_fcs_insert.sv
// rtl/mac_tx_fcs_insert.sv - TX MAC stage: optional zero pad to minimum length, then 4-byte FCS
// Padding (PAD state and byte counter) is built only when MAC_TX_FCS_PAD_EN is defined.
module mac_tx_fcs_insert
  import mac_tx_fcs_insert_pkg::*;
#(
  parameter int MIN_FRAME_LEN = ETH_MIN_FRAME_LEN,
  parameter int CNT_WIDTH     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser
);

  localparam logic [1:0] LAST_IDX = 2'(ETH_FCS_LEN - 1);

  generate
    if ((1 << CNT_WIDTH) <= MIN_FRAME_LEN) begin : g_bad_cfg
      $error("CNT_WIDTH too small for MIN_FRAME_LEN");
    end
  endgenerate

  tx_fcs_state_t r_state, w_state_next;
  logic [1:0]    r_fcs_idx, w_idx_next;
  logic          r_err;
  logic [7:0]    r_tdata;
  logic          r_tvalid, r_tlast, r_tuser;

  logic          w_adv, w_in_fire;
  logic          w_load, w_last, w_user;
  logic [7:0]    w_byte, w_fcs_byte;
  logic          w_crc_adv, w_crc_reload, w_latch_err;
  logic [31:0]   w_crc;

  assign w_adv         = m_axis_tready || !r_tvalid;
  assign s_axis_tready = w_adv && ((r_state == IDLE) || (r_state == DATA));
  assign w_in_fire     = s_axis_tvalid && s_axis_tready;
  assign w_fcs_byte    = w_crc[{r_fcs_idx, 3'b000} +: 8] ^ {8{r_err}};

`ifdef MAC_TX_FCS_PAD_EN
  localparam logic [CNT_WIDTH-1:0] MIN_CNT = CNT_WIDTH'(MIN_FRAME_LEN);

  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_inc, w_cnt_next;

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_fcs_idx;
    w_load       = 1'b0;
    w_byte       = 8'h00;
    w_last       = 1'b0;
    w_user       = 1'b0;
    w_crc_adv    = 1'b0;
    w_crc_reload = 1'b0;
    w_latch_err  = 1'b0;
`ifdef MAC_TX_FCS_PAD_EN
    w_cnt_next   = r_cnt;
`endif
    case (r_state)
      IDLE, DATA: begin
        if (w_in_fire) begin
          w_load       = 1'b1;
          w_byte       = s_axis_tdata;
          w_crc_adv    = 1'b1;
          w_state_next = DATA;
`ifdef MAC_TX_FCS_PAD_EN
          w_cnt_next   = w_cnt_inc;
`endif
          if (s_axis_tlast) begin
            w_latch_err  = 1'b1;
            w_idx_next   = '0;
            w_state_next = FCS;
`ifdef MAC_TX_FCS_PAD_EN
            if (w_cnt_inc < MIN_CNT) begin
              w_state_next = PAD;
            end
`endif
          end
        end
      end
`ifdef MAC_TX_FCS_PAD_EN
      PAD: begin
        if (w_adv) begin
          w_load     = 1'b1;
          w_crc_adv  = 1'b1;
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc == MIN_CNT) begin
            w_state_next = FCS;
          end
        end
      end
`endif
      FCS: begin
        if (w_adv) begin
          w_load = 1'b1;
          w_byte = w_fcs_byte;
          if (r_fcs_idx == LAST_IDX) begin
            w_last       = 1'b1;
            w_user       = r_err;
            w_crc_reload = 1'b1;
            w_state_next = IDLE;
`ifdef MAC_TX_FCS_PAD_EN
            w_cnt_next   = '0;
`endif
          end else begin
            w_idx_next = r_fcs_idx + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fcs_idx <= '0;
      r_err     <= 1'b0;
      r_tdata   <= 8'h00;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tuser   <= 1'b0;
    end else begin
      r_fcs_idx <= w_idx_next;
      if (w_latch_err) begin
        r_err <= s_axis_tuser;
      end
      if (w_adv) begin
        r_tvalid <= w_load;
        r_tlast  <= w_last;
        r_tuser  <= w_user;
        if (w_load) begin
          r_tdata <= w_byte;
        end
      end
    end
  end

  // CRC restarts right after the last FCS byte so a back-to-back frame sees a fresh seed.
  mac_lfsr #(
    .LFSR_POLY  (CRC32_POLY),
    .LFSR_INIT  (CRC32_INIT),
    .LFSR_XOROUT(CRC32_XOROUT),
    .REVERSE    (1'b1),
    .DATA_WIDTH (8)
  ) u_crc (
    .i_clk       (clk),
    .i_rst       (rst || w_crc_reload),
    .i_data      (w_byte),
    .i_data_valid(w_crc_adv),
    .o_lfsr_state(w_crc)
  );

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;

endmodule

// File: tb/tb_mac_tx_fcs_insert.sv
// tb/tb_mac_tx_fcs_insert.sv - self-checking bench for mac_tx_fcs_insert (honours MAC_TX_FCS_PAD_EN)
module tb_mac_tx_fcs_insert;

  localparam int MIN_LEN = 60;
`ifdef MAC_TX_FCS_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tready, s_tlast, s_tuser;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tready, m_tlast, m_tuser;

  always #5 clk = ~clk;

  mac_tx_fcs_insert #(
    .MIN_FRAME_LEN(MIN_LEN),
    .CNT_WIDTH    (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .s_axis_tuser (s_tuser),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .m_axis_tuser (m_tuser)
  );

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       user;
    int         cyc;
  } beat_t;

  typedef struct {
    int          len;
    int          kind;
    bit          user;
    int          exp_beats;
    bit          chk_const;
    logic [31:0] fcs_const;
  } vec_t;

  beat_t      mon_q[$];
  logic [7:0] g_pay[$];
  logic [7:0] g_exp[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         gap_pct = 0;
  int         rdy_pct = 100;
  int         g_first_cyc, g_last_cyc;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold", {23'h0, m_tvalid, m_tdata}, {23'h0, 1'b1, prev_data});
      end
      if (m_tvalid && m_tready) begin
        mon_q.push_back('{m_tdata, m_tlast, m_tuser, cyc});
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: reflected CRC-32, one bit at a time, over the padded frame.
  function automatic logic [31:0] crc32_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, g_exp[i]};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  function automatic void build_expected(input bit user);
    logic [31:0] f;
    g_exp = g_pay;
    if (PAD_ON) begin
      while (g_exp.size() < MIN_LEN) g_exp.push_back(8'h00);
    end
    f = crc32_of(g_exp.size());
    if (user) f = ~f;
    for (int k = 0; k < 4; k++) g_exp.push_back(f[8*k +: 8]);
  endfunction

  function automatic void make_payload(input int kind, input int len);
    g_pay.delete();
    for (int i = 0; i < len; i++) begin
      case (kind)
        0:       g_pay.push_back(8'(8'h31 + i));
        1:       g_pay.push_back(8'hAA);
        2:       g_pay.push_back(8'($urandom));
        default: g_pay.push_back(8'(i));
      endcase
    end
  endfunction

  task automatic sync_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int abort_at, input bit user);
    int guard;
    bit fire;
    for (int i = 0; i < g_pay.size(); i++) begin
      if (i == abort_at) break;
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = g_pay[i];
      s_tlast  = (i == g_pay.size() - 1);
      s_tuser  = s_tlast & user;
      fire  = 1'b0;
      guard = 0;
      while (!fire && guard < 5000) begin
        @(negedge clk);
        fire = s_tready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!fire) begin
        note_timeout("src_accept");
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic check_frame(input string name, input bit user, input int exp_beats,
                             input bit chk_const, input logic [31:0] fcs_const);
    beat_t       got[$];
    int          guard;
    bit          found;
    int          bad;
    int          n;
    logic [31:0] w;
    guard = 0;
    found = 1'b0;
    while (!found && guard < 5000) begin
      foreach (mon_q[k]) if (mon_q[k].last) found = 1'b1;
      if (!found) begin
        @(posedge clk);
        #2;
        guard++;
      end
    end
    if (!found) begin
      note_timeout({name, "_tlast"});
      return;
    end
    do got.push_back(mon_q.pop_front()); while (!got[got.size()-1].last);
    n = got.size();
    chk({name, "_len"}, 32'(n), 32'(g_exp.size()));
    bad = -1;
    for (int k = 0; k < n && k < g_exp.size(); k++) begin
      if (bad < 0 && (got[k].d !== g_exp[k] || (k < n - 1 && got[k].user !== 1'b0))) bad = k;
    end
    chk({name, "_first_bad_idx"}, 32'(bad), 32'hFFFFFFFF);
    chk({name, "_tuser"}, 32'(got[n-1].user), 32'(user));
    if (exp_beats > 0) chk({name, "_beats"}, 32'(n), 32'(exp_beats));
    if (chk_const && n >= 4) begin
      w = {got[n-1].d, got[n-2].d, got[n-3].d, got[n-4].d};
      chk({name, "_fcs"}, w, fcs_const);
    end
    g_first_cyc = got[0].cyc;
    g_last_cyc  = got[n-1].cyc;
  endtask

  initial begin
    vec_t       vecs[7];
    logic [7:0] pay1[$];
    logic [7:0] exp1[$];
    int         last1;
    int         nlast;
    bit         u;

    vecs[0] = '{9,    0, 1'b0, PAD_ON ? 64 : 13, !PAD_ON, 32'hCBF43926};
    vecs[1] = '{9,    0, 1'b1, PAD_ON ? 64 : 13, !PAD_ON, 32'h340BC6D9};
    vecs[2] = '{1,    1, 1'b0, PAD_ON ? 64 : 5,  1'b0,    32'h0};
    vecs[3] = '{59,   3, 1'b0, PAD_ON ? 64 : 63, 1'b0,    32'h0};
    vecs[4] = '{60,   2, 1'b0, 64,               1'b0,    32'h0};
    vecs[5] = '{61,   2, 1'b1, 65,               1'b0,    32'h0};
    vecs[6] = '{1500, 3, 1'b0, 1504,             1'b0,    32'h0};

    rst      = 1'b1;
    s_tdata  = 8'h00;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'h0);
    chk("rst_m_tlast",  32'(m_tlast),  32'h0);
    chk("rst_m_tuser",  32'(m_tuser),  32'h0);
    chk("rst_m_tdata",  32'(m_tdata),  32'h0);
    chk("rst_s_tready", 32'(s_tready), 32'h1);

    for (int v = 0; v < 7; v++) begin
      make_payload(vecs[v].kind, vecs[v].len);
      build_expected(vecs[v].user);
      sync_drive();
      send_frame(-1, vecs[v].user);
      check_frame($sformatf("vec%0d", v), vecs[v].user, vecs[v].exp_beats,
                  vecs[v].chk_const, vecs[v].fcs_const);
    end

    gap_pct = 30;
    rdy_pct = 50;
    for (int r = 0; r < 4; r++) begin
      u = (r == 3);
      make_payload(2, (r % 2 == 0) ? 64 : 10 + r);
      build_expected(u);
      sync_drive();
      send_frame(-1, u);
      check_frame($sformatf("stall%0d", r), u, (r == 0) ? 68 : -1, 1'b0, 32'h0);
    end
    gap_pct = 0;
    rdy_pct = 100;
    repeat (3) @(posedge clk);

    make_payload(2, 60);
    pay1 = g_pay;
    build_expected(1'b0);
    exp1 = g_exp;
    sync_drive();
    send_frame(-1, 1'b0);
    make_payload(2, 60);
    send_frame(-1, 1'b0);
    pay1 = g_pay;
    g_exp = exp1;
    check_frame("b2b_first", 1'b0, 64, 1'b0, 32'h0);
    last1 = g_last_cyc;
    g_pay = pay1;
    build_expected(1'b0);
    check_frame("b2b_second", 1'b0, 64, 1'b0, 32'h0);
    chk("b2b_gap_cycles", 32'(g_first_cyc - last1), 32'h1);

    make_payload(2, 40);
    sync_drive();
    send_frame(20, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_m_tvalid", 32'(m_tvalid), 32'h0);
    chk("midrst_m_tlast",  32'(m_tlast),  32'h0);
    nlast = 0;
    foreach (mon_q[k]) if (mon_q[k].last) nlast++;
    chk("midrst_no_tlast", 32'(nlast), 32'h0);
    mon_q.delete();
    sync_drive();
    rst = 1'b0;
    make_payload(0, 9);
    build_expected(1'b0);
    send_frame(-1, 1'b0);
    check_frame("post_rst", 1'b0, PAD_ON ? 64 : 13, !PAD_ON, 32'hCBF43926);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
